// File: rtl/axis_switch_out_port.sv
// rtl/axis_switch_out_port.sv - AXI-Stream switch output port: grant consumer, packet lock, 2-entry output buffer
module axis_switch_out_port #(
    parameter int N_IN   = 8,
    parameter int DATA_W = 32,
    parameter int ID_W   = $clog2(N_IN)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [N_IN*DATA_W-1:0] s_tdata_i,
    input  logic [N_IN-1:0]        s_tlast_i,
    input  logic [N_IN-1:0]        s_tvalid_i,
    output logic [N_IN-1:0]        s_tready_o,
    output logic [N_IN-1:0]        arb_req_o,
    input  logic [ID_W-1:0]        arb_gnt_id_i,
    input  logic                   arb_gnt_vld_i,
    output logic                   arb_gnt_rdy_o,
    output logic [DATA_W-1:0]      m_tdata_o,
    output logic                   m_tlast_o,
    output logic [ID_W-1:0]        m_tid_o,
    output logic                   m_tvalid_o,
    input  logic                   m_tready_i
);

    typedef enum logic {S_IDLE = 1'b0, S_ACTIVE = 1'b1} state_e;

    // One extra bit so that N_IN itself is representable for the range check
    localparam logic [ID_W:0] N_IN_EXT = (ID_W+1)'(N_IN);

    state_e            state_q, state_d;
    logic [ID_W-1:0]   sel_q, sel_d;
    logic [1:0]        count_q, count_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0] buf_data_q [2];
    logic              buf_last_q [2];
    logic [ID_W-1:0]   buf_id_q   [2];

    logic              idle_ok;
    logic              active_ok;
    logic              has_space;
    logic              gnt_in_range;
    logic              gnt_fire;
    logic              in_fire;
    logic              out_fire;
    logic              sel_tvalid;
    logic              sel_tlast;
    logic [DATA_W-1:0] sel_tdata;

    // Crossbar: route the owning input's stream signals to the buffer write port
    always_comb begin
        sel_tvalid = 1'b0;
        sel_tlast  = 1'b0;
        sel_tdata  = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (sel_q == ID_W'(i)) begin
                sel_tvalid = s_tvalid_i[i];
                sel_tlast  = s_tlast_i[i];
                sel_tdata  = s_tdata_i[i*DATA_W +: DATA_W];
            end
        end
    end

    // Reset gates every handshake facing the arbiter and the sources.
    // Ready depends only on the registered count, never on m_tready_i.
    assign idle_ok      = reset_n && (state_q == S_IDLE);
    assign active_ok    = reset_n && (state_q == S_ACTIVE);
    assign has_space    = (count_q != 2'd2);
    assign gnt_in_range = ({1'b0, arb_gnt_id_i} < N_IN_EXT);
    assign gnt_fire     = arb_gnt_vld_i && idle_ok;
    assign in_fire      = active_ok && has_space && sel_tvalid;
    assign out_fire     = (count_q != 2'd0) && m_tready_i;

    // FSM state register and owning-input register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
        end
    end

    // FSM next state: lock on an in-range grant, release after the tlast beat
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        case (state_q)
            S_IDLE: begin
                if (gnt_fire && gnt_in_range) begin
                    state_d = S_ACTIVE;
                    sel_d   = arb_gnt_id_i;
                end
            end
            S_ACTIVE: begin
                if (in_fire && sel_tlast) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: requests and grant-ready only in IDLE, source ready only to the owner
    always_comb begin
        arb_gnt_rdy_o = idle_ok;
        arb_req_o     = idle_ok ? s_tvalid_i : '0;
        s_tready_o    = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (active_ok && has_space && (sel_q == ID_W'(i))) begin
                s_tready_o[i] = 1'b1;
            end
        end
    end

    // Output buffer occupancy and pointer next state
    always_comb begin
        wr_ptr_d = in_fire  ? ~wr_ptr_q : wr_ptr_q;
        rd_ptr_d = out_fire ? ~rd_ptr_q : rd_ptr_q;
        case ({in_fire, out_fire})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // Output buffer control registers; reset discards any queued beats
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_q  <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Output buffer storage; contents are only observed while count is non-zero
    always_ff @(posedge clk) begin
        if (in_fire) begin
            buf_data_q[wr_ptr_q] <= sel_tdata;
            buf_last_q[wr_ptr_q] <= sel_tlast;
            buf_id_q[wr_ptr_q]   <= sel_q;
        end
    end

    // Master stream from the head entry, forced to zero when empty
    assign m_tvalid_o = (count_q != 2'd0);
    assign m_tdata_o  = m_tvalid_o ? buf_data_q[rd_ptr_q] : '0;
    assign m_tlast_o  = m_tvalid_o ? buf_last_q[rd_ptr_q] : 1'b0;
    assign m_tid_o    = m_tvalid_o ? buf_id_q[rd_ptr_q]   : '0;

endmodule

// File: doc/axis_switch_out_port.md
# axis_switch_out_port

Output port of the AXI Stream switch: the grant consumer that sits after `irr_arbiter`. It presents the N input `tvalid` lines to the arbiter as requests and accepts one grant at a time through the `gnt_vld`/`gnt_rdy` handshake. It then locks the crossbar to the granted input until that input's `tlast` beat, and drives the master stream through a 2-entry output buffer.

## Interface
- `N_IN`, 8, number of slave stream inputs (≥2, need not be a power of two)
- `DATA_W`, 32, `tdata` width
- `ID_W`, `$clog2(N_IN)`, width of grant index and `m_tid_o`
- `clk`  in  1  clock; all logic on rising edge
- `reset_n`  in  1  synchronous, active-low reset
- `s_tdata_i`  in  `N_IN×DATA_W`  packed per-input data
- `s_tlast_i`  in  `N_IN`  per-input last
- `s_tvalid_i`  in  `N_IN`  per-input valid
- `s_tready_o`  out  `N_IN`  per-input ready
- `arb_req_o`  out  `N_IN`  requests to arbiter
- `arb_gnt_id_i`  in  `ID_W`  granted input index
- `arb_gnt_vld_i`  in  1  grant valid
- `arb_gnt_rdy_o`  out  1  grant accepted; doubles as the arbiter's pointer-advance enable
- `m_tdata_o`  out  `DATA_W`  output data
- `m_tlast_o`  out  1  output last
- `m_tid_o`  out  `ID_W`  source input index of the current beat
- `m_tvalid_o`  out  1  output valid
- `m_tready_i`  in  1  output ready

## Operation
- **FSM states:**
  - `IDLE`: no input selected.
  - `ACTIVE`: input `sel` owns the port.
- **`arb_req_o` and `arb_gnt_rdy_o`:**
  - `arb_req_o = s_tvalid_i` in `IDLE`. It is all zeros in `ACTIVE`, so the arbiter pointer does not move mid-packet.
  - `arb_gnt_rdy_o = (state == IDLE)`.
- **`IDLE` → `ACTIVE`:** on `arb_gnt_vld_i & arb_gnt_rdy_o` with `arb_gnt_id_i < N_IN`. Register `sel <= arb_gnt_id_i`.
  - A grant with `arb_gnt_id_i ≥ N_IN` is consumed: the handshake completes and the FSM stays in `IDLE`.
- **Input ready:** in `ACTIVE`, `s_tready_o[sel] = (count < 2)`. All other `s_tready_o` bits are 0. All bits are 0 in `IDLE`.
- **Input beat:** `s_tvalid_i[sel] & s_tready_o[sel]`. Push `{tdata, tlast, sel}` into the output buffer.
  - A beat with `tlast = 1` returns the FSM to `IDLE` on the next edge.
- **Output buffer:** 2-entry FIFO with registered `count` (0..2). `m_*` are driven from the head entry and `m_tvalid_o = (count != 0)`.
  - Push and pop in the same cycle leave `count` unchanged.
  - The buffer keeps draining in `IDLE`. The next packet's beats queue behind the previous tail.
- **Output ordering:** beats leave in input order. Packets are never interleaved, and `m_tid_o` is constant within a packet.
- **Reset (`reset_n = 0` at an edge, including mid-packet):**
  - State: `state = IDLE`, `sel = 0`, `count = 0`. Buffer contents are discarded and any partial packet is truncated without `tlast`.
  - Outputs: `m_tvalid_o = 0`, `s_tready_o = 0`, `arb_req_o = 0`, `arb_gnt_rdy_o = 0`. The last two are gated by `reset_n`, so grants are not accepted while reset is asserted.
  - `m_tdata_o`, `m_tlast_o` and `m_tid_o` read 0.

## Timing
- **Latency:**
  - Grant accepted at cycle T → `ACTIVE` at T+1 → first input beat accepted at T+1 at the earliest.
  - That beat appears on `m_*` at T+2.
- **Throughput:** with `m_tready_i = 1`, one beat per cycle within a packet.
- **Gap between packets:** one cycle, the `IDLE` cycle after `tlast`. The next grant can be accepted in that cycle.
- **Single-beat packet:** `ACTIVE` for exactly one cycle when `count < 2`.
- **Back-pressure:** `m_tready_i = 0` fills the buffer within 2 beats, after which `s_tready_o[sel]` drops on the following cycle. No beat is ever lost or duplicated.
- **Output stability:** `m_*` hold steady while `m_tvalid_o & ~m_tready_i`.
- **Grant inputs:** `arb_gnt_id_i` and `arb_gnt_vld_i` are sampled only while `arb_gnt_rdy_o = 1`. Changes in other cycles are ignored.
- **Path isolation:** there is no combinational path from `m_tready_i` to `s_tready_o` (ready depends only on the registered `count`).

## Test plan
- **Single source:** `N_IN = 8`. Input 3 sends a 4-beat packet (data `0xA0..0xA3`) with `m_tready_i = 1`.
  - Expect one grant handshake, then `m_tdata_o` = `A0,A1,A2,A3` on consecutive cycles starting at T+2.
  - `m_tid_o = 3` throughout, `m_tlast_o` only on `A3`, `arb_req_o = 0` while `ACTIVE`.
- **Contention:** inputs 0, 2 and 5 each hold a 2-beat packet, with the arbiter attached.
  - Expect packets to leave in order 0, 2, 5, unbroken, with exactly one idle output cycle between packets.
- **Back-pressure:** hold `m_tready_i = 0` for 6 cycles during a 5-beat packet.
  - Expect `count` to stop at 2 and `s_tready_o[sel] = 0` while full.
  - After release, all 5 beats arrive intact and in order.
- **Single-beat packets, `N_IN = 5`:** inputs 4 then 0 each send one beat with `tlast = 1`.
  - Expect `sel` to wrap from 4 to 0 and two `m_tlast_o` beats.
  - Also drive a forced grant with id 6: it is consumed with no state change.
- **Mid-packet reset:** assert `reset_n = 0` for 1 cycle after beat 2 of 4.
  - Next cycle: `m_tvalid_o = 0`, `s_tready_o = 0`, `arb_gnt_rdy_o = 0`.
  - After release, a fresh grant is accepted and the new packet passes intact.
